// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode 0, MSB-first SPI initiator with start/busy/done handshake
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ce0,
  input  logic                  miso
);

  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state, state_next;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-2:0] tx_sreg;
  logic [DATA_WIDTH-1:0] rx_sreg;
  logic                  tick, last_bit, gap_end;

  assign tick     = (timer == TW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH));
  assign gap_end  = (gap_cnt == GW'(CS_GAP - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (tick && sclk && last_bit) state_next = HOLD;
      HOLD:    if (tick) state_next = GAP;
      GAP:     if (tick && gap_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Every state change out of a timed state lands on a tick, so clearing on
  // tick also restarts the timer on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      timer <= '0;
    else if (state == IDLE || tick)  timer <= '0;
    else                             timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ce0     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      rx_sreg <= '0;
      tx_sreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tx_sreg <= tx_data[DATA_WIDTH-2:0];
          mosi    <= tx_data[DATA_WIDTH-1];
          ce0     <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= '0;
        end
        SETUP: if (tick) begin
          sclk    <= 1'b1;
          rx_sreg <= {rx_sreg[DATA_WIDTH-2:0], miso};
          bit_cnt <= bit_cnt + 1'b1;
        end
        SHIFT: if (tick) begin
          if (sclk) begin
            sclk <= 1'b0;
            if (!last_bit) begin
              mosi    <= tx_sreg[DATA_WIDTH-2];
              tx_sreg <= tx_sreg << 1;
            end
          end else begin
            sclk    <= 1'b1;
            rx_sreg <= {rx_sreg[DATA_WIDTH-2:0], miso};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HOLD: if (tick) begin
          ce0     <= 1'b1;
          mosi    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_sreg;
          gap_cnt <= '0;
        end
        GAP: if (tick) begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master with loopback, tie-high and responder model
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sclk, mosi, ce0, miso;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;

  // 0: loopback, 1: tied high, 2: responder model
  int mode = 0;

  logic [7:0] per_sr = 8'h00;
  logic [7:0] per_rx = 8'h00;
  logic [7:0] per_word = 8'h3C;

  int   rise_cnt = 0, low_cnt = 0, done_cnt = 0, mosi_hi_cnt = 0;
  int   high_run = 0, last_gap = 0;
  logic sclk_prev = 1'b0, ce0_prev = 1'b1;
  logic [7:0] mosi_bits = 8'h00;

  spi_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .ce0     (ce0),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : per_sr[7];

  always @(negedge ce0) per_sr <= per_word;
  always @(posedge sclk) per_rx <= {per_rx[6:0], mosi};
  always @(negedge sclk) if (!ce0) per_sr <= {per_sr[6:0], 1'b0};

  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      rise_cnt  <= rise_cnt + 1;
      mosi_bits <= {mosi_bits[6:0], mosi};
    end
    if (!ce0) low_cnt <= low_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mosi) mosi_hi_cnt <= mosi_hi_cnt + 1;
    if (ce0) high_run <= high_run + 1;
    else if (ce0_prev) begin
      last_gap <= high_run;
      high_run <= 0;
    end
    sclk_prev <= sclk;
    ce0_prev  <= ce0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    int r0, l0, d0, h0, n;
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ce0", 32'(ce0), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    mode = 0;
    r0 = rise_cnt; l0 = low_cnt; d0 = done_cnt;
    pulse_start(8'hA5);
    chk("a5_busy", 32'(busy), 32'd1);
    chk("a5_ce0", 32'(ce0), 32'd0);
    chk("a5_mosi_msb", 32'(mosi), 32'd1);
    wait_done("a5_done_to");
    chk("a5_rx", 32'(rx_data), 32'hA5);
    chk("a5_ce0_at_done", 32'(ce0), 32'd1);
    @(negedge clk);
    chk("a5_done_1cyc", 32'(done), 32'd0);
    wait_idle("a5_idle_to");
    chk("a5_rises", 32'(rise_cnt - r0), 32'd8);
    chk("a5_ce0_low", 32'(low_cnt - l0), 32'd68);
    chk("a5_dones", 32'(done_cnt - d0), 32'd1);
    chk("a5_mosi_bits", 32'(mosi_bits), 32'hA5);

    // miso tied high, sending zeros
    mode = 1;
    h0 = mosi_hi_cnt;
    pulse_start(8'h00);
    wait_done("ff_done_to");
    chk("ff_rx", 32'(rx_data), 32'hFF);
    wait_idle("ff_idle_to");
    chk("ff_mosi_low", 32'(mosi_hi_cnt - h0), 32'd0);

    // Responder model
    mode = 2;
    per_word = 8'h3C;
    pulse_start(8'h12);
    wait_done("per_done_to");
    chk("per_rx_master", 32'(rx_data), 32'h3C);
    wait_idle("per_idle_to");
    chk("per_rx_slave", 32'(per_rx), 32'h12);

    // start re-pulsed mid-transfer must be ignored
    mode = 0;
    d0 = done_cnt;
    pulse_start(8'h3C);
    repeat (20) @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done("ign_done_to");
    chk("ign_rx", 32'(rx_data), 32'h3C);
    wait_idle("ign_idle_to");
    repeat (10) @(negedge clk);
    chk("ign_mosi_bits", 32'(mosi_bits), 32'h3C);
    chk("ign_dones", 32'(done_cnt - d0), 32'd1);

    // start held high: back-to-back transfers
    d0 = done_cnt;
    @(negedge clk);
    tx_data = 8'h81;
    start   = 1'b1;
    n = 0;
    while ((done_cnt - d0) < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_two_dones_to", 32'(n < 1000), 32'd1);
    n = 0;
    while (ce0 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_restart_to", 32'(n < 100), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_gap_ge9", 32'(last_gap >= 9), 32'd1);
    wait_idle("b2b_idle_to");
    @(negedge clk);
    chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
    chk("b2b_rx", 32'(rx_data), 32'h81);

    // Reset mid-transfer after the 4th rising edge
    r0 = rise_cnt;
    pulse_start(8'hC3);
    n = 0;
    while ((rise_cnt - r0) < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rise4_to", 32'(n < 400), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_sclk", 32'(sclk), 32'd0);
    chk("mid_ce0", 32'(ce0), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rx", 32'(rx_data), 32'h00);
    chk("mid_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start(8'h5A);
    wait_done("post_done_to");
    chk("post_rx", 32'(rx_data), 32'h5A);
    wait_idle("post_idle_to");
    chk("post_dones", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI controller (initiator) that drives the same 4-wire link our SPI peripheral receives: sclk, mosi, ce0 out; miso in.
- Used for FPGA-to-FPGA bring-up and loopback testing against our own peripheral block, and for driving external SPI devices.
- Mode 0 (CPOL=0, CPHA=0), MSB first, one DATA_WIDTH-bit full-duplex word per transfer.
- Simple start/busy/done handshake toward user logic.

Parameters:
- DATA_WIDTH, 8, bits per transfer.
- CLK_DIV, 4, clk cycles per sclk half-period. Legal values ≥1. Resulting sclk = clk/(2*CLK_DIV).
- CS_GAP, 2, number of sclk half-periods that ce0 stays high after a transfer before the next start is accepted. Legal values ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transfer; sampled only in IDLE.
- tx_data  in  DATA_WIDTH  word to send; captured in the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until the end of GAP.
- done  out  1  one-cycle pulse; rx_data is valid from this cycle.
- rx_data  out  DATA_WIDTH  last received word; held until the next done.
- sclk  out  1  serial clock; idles low.
- mosi  out  1  serial data out.
- ce0  out  1  chip enable, active low.
- miso  in  1  serial data in; the bench/top synchronises it if it comes from off-chip.

Behaviour:
- Reset (async, rst_n=0), taking effect immediately, including mid-transfer:
  - sclk=0, ce0=1, mosi=0, busy=0, done=0, rx_data=0.
  - State returns to IDLE; counters are cleared.
  - No partial rx_data update occurs.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- Half-period timer:
  - Counts CLK_DIV clk cycles in every state except IDLE.
  - Restarts at 0 on each state entry and at each half-period boundary.
- IDLE, with start=1:
  - Load shift register with tx_data.
  - Next cycle: ce0=0, mosi=tx_data[DATA_WIDTH-1], busy=1, state SETUP.
  - start=0: remain in IDLE.
- SETUP: after one half-period, sclk rises and the state moves to SHIFT.
- SHIFT, rising-edge half:
  - On the same cycle sclk goes 1, miso is sampled into the LSB of the receive shift register.
  - The bit counter increments.
- SHIFT, falling-edge half:
  - sclk goes 0.
  - If fewer than DATA_WIDTH bits have been sampled, the next tx bit is shifted onto mosi and the state remains SHIFT.
  - Otherwise the state moves to HOLD, and mosi keeps the last bit.
- HOLD: after one half-period:
  - ce0=1, mosi=0, done=1 for one cycle.
  - rx_data is loaded from the receive shift register.
  - State moves to GAP.
- GAP: after CS_GAP half-periods, busy=0 and the state returns to IDLE.
  - start is not accepted before IDLE.
  - With start held high, the next transfer is accepted in the first IDLE cycle.
- Timing: with t0 = the cycle ce0 falls:
  - rising edge k (k=1..DATA_WIDTH) at t0+(2k-1)*CLK_DIV.
  - falling edge k at t0+2k*CLK_DIV.
  - ce0 rises, and done pulses, at t0+(2*DATA_WIDTH+1)*CLK_DIV.
  - Defaults: ce0 low for 68 cycles; 8 rising edges.
- sclk glitch-free: sclk, mosi and ce0 are all driven from registers.
- start asserted while busy=1 is ignored; tx_data is not re-sampled.
- rx_data changes only on the cycle done=1.

Test Plan:
- Defaults, miso looped to mosi, start 1 cycle with tx_data=0xA5:
  - Exactly 8 sclk rising edges; ce0 low for 68 cycles.
  - mosi bit sequence 1,0,1,0,0,1,0,1 at rising edges.
  - done one cycle; rx_data=0xA5.
- miso tied 1, tx_data=0x00 → rx_data=0xFF; mosi stays 0 throughout.
- Our SPI peripheral as responder, with its outgoing word set to 0x3C, tx_data=0x12:
  - rx_data=0x3C.
  - The peripheral's incoming word is 0x12.
- start pulsed again mid-transfer with tx_data=0xFF:
  - Ignored; the in-flight transfer completes with its original data.
  - Exactly one done pulse.
- start held high continuously, tx_data=0x81:
  - Consecutive transfers, each with a done pulse.
  - ce0 high for at least CS_GAP*CLK_DIV+1 = 9 cycles between transfers.
- rst_n pulsed low after the 4th rising edge:
  - Immediately sclk=0, ce0=1, busy=0, rx_data=0x00; no done pulse.
  - A subsequent start with tx_data=0x5A then completes normally.
